imem_rsp: RTL and testbench
===========================

# imem_rsp

Instruction-memory responder for the NPC core: the memory end of the fetch interface. It accepts a 32-bit fetch address from the core over a valid/ready request channel, reads one word from an internal word-addressed array, and returns the instruction over a valid/ready response channel after a programmable latency. A separate write-only load port lets the simulation harness preload program images.

## Interface
- DEPTH, 4096: array size in 32-bit words; power of two.
- BASE, 32'h8000_0000: byte address of word 0.
- LAT, 1: extra wait cycles between request acceptance and response (0..255).
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_req_valid  in  1  fetch request present.
- o_req_ready  out  1  responder can accept a request.
- i_req_addr  in  32  fetch byte address (pc).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  core consumes the response.
- o_rsp_ins  out  32  fetched instruction word.
- o_rsp_err  out  1  request was misaligned or outside [BASE, BASE+4*DEPTH).
- i_ld_wen  in  1  load-port write enable.
- i_ld_addr  in  log2(DEPTH)  load-port word index.
- i_ld_data  in  32  load-port write data.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: o_req_ready=1. On i_req_valid: latch address, read array word, latch error flag, load counter with LAT; next state BUSY if LAT>0, else RESP.
- BUSY: counter decrements each cycle; at counter==1 next state RESP. o_req_ready=0, o_rsp_valid=0.
- RESP: o_rsp_valid=1, o_rsp_ins/o_rsp_err held stable. On i_rsp_ready: next state IDLE. o_req_ready=0 (no overlap; one outstanding request).
- Word index = (i_req_addr - BASE) >> 2, truncated to log2(DEPTH) bits.
- Error (when enabled): addr[1:0]!=0, or addr<BASE, or addr>=BASE+4*DEPTH. On error o_rsp_ins=32'h0000_0000, o_rsp_err=1; the response is still delivered through the normal handshake.
- Load port: i_ld_wen writes i_ld_data to array[i_ld_addr] on the edge, in any state, including during reset. Array contents are never cleared by reset.
- Same-edge load write and request acceptance on the same word: request returns the old word (read-before-write).

## Timing
- Reset (asynchronous, i_rst_n=0): state IDLE, o_req_ready=1 once released (0 while asserted), o_rsp_valid=0, o_rsp_ins=0, o_rsp_err=0, counter=0.
- Acceptance edge = edge where i_req_valid & o_req_ready.
- o_rsp_valid rises exactly LAT+1 cycles after the acceptance edge (LAT=0: next cycle).
- Response retire edge = edge where o_rsp_valid & i_rsp_ready; o_req_ready returns to 1 in the following cycle.
- Minimum request-to-request spacing: LAT+2 cycles.
- i_rsp_ready held low: response held indefinitely with unchanged data.
- i_rsp_ready high before o_rsp_valid: no effect.
- Reset asserted in BUSY or RESP: in-flight request dropped, no response issued after release.
- All outputs are register-driven; no combinational path from any input to any output except none.

## Configuration
- IMEM_ERR_EN defined: range/alignment check as above; o_rsp_err reflects the check.
- IMEM_ERR_EN undefined: no check; index taken from address bits modulo DEPTH (misaligned low bits ignored), o_rsp_err tied 0, out-of-range addresses alias into the array.

## Test plan
- Reset: hold i_rst_n=0 mid-BUSY (LAT=3) -> o_rsp_valid=0, o_rsp_ins=0, state IDLE; release -> o_req_ready=1, no stale response ever appears.
- Preload array[0]=32'h0010_0093, array[1]=32'h0010_0073; request 0x8000_0000 then 0x8000_0004 with LAT=1 -> responses 32'h0010_0093, 32'h0010_0073, each valid 2 cycles after acceptance, err=0.
- LAT=0 back-to-back with i_rsp_ready=1 -> valid 1 cycle after acceptance, next acceptance 2 cycles after previous.
- Backpressure: i_rsp_ready=0 for 5 cycles in RESP -> o_rsp_valid and o_rsp_ins stable, o_req_ready=0 throughout.
- IMEM_ERR_EN: request 0x8000_0002 and 0x7FFF_FFFC -> err=1, ins=0; without macro, 0x8000_0002 returns array[0], err=0.
- Same-edge load of array[2]=32'hDEAD_BEEF with request 0x8000_0008 -> old word returned; repeat request -> 32'hDEAD_BEEF.

Source files
------------

// File: rtl/imem_rsp.sv
// imem_rsp: instruction-memory responder with a programmable response latency and a preload port.
// Define IMEM_ERR_EN to enable range/alignment checking of fetch addresses.
module imem_rsp #(
  parameter int unsigned DEPTH = 4096,
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int unsigned LAT   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [31:0]              i_req_addr,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [31:0]              o_rsp_ins,
  output logic                     o_rsp_err,
  input  logic                     i_ld_wen,
  input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
  input  logic [31:0]              i_ld_data
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [7:0]  LAT_W = 8'(LAT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [7:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          req_err;
  logic [31:0]   rd_word;

  always_comb begin
    idx = AW'((i_req_addr - BASE) >> 2);
`ifdef IMEM_ERR_EN
    req_err = (i_req_addr[1:0] != 2'b00) ||
              (i_req_addr < BASE) ||
              ({1'b0, i_req_addr} >= ({1'b0, BASE} + (33'(DEPTH) << 2)));
`else
    req_err = 1'b0;
`endif
    rd_word = req_err ? '0 : mem[idx];
  end

  // Preload port is independent of reset; the FSM samples mem before this edge's write lands.
  always_ff @(posedge i_clk) begin
    if (i_ld_wen) begin
      mem[i_ld_addr] <= i_ld_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      o_req_ready <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_ins   <= '0;
      o_rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            o_rsp_ins   <= rd_word;
            o_rsp_err   <= req_err;
            cnt         <= LAT_W;
            o_req_ready <= 1'b0;
            if (LAT_W == 8'd0) begin
              state       <= RESP;
              o_rsp_valid <= 1'b1;
            end else begin
              state <= BUSY;
            end
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        BUSY: begin
          cnt <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            state       <= RESP;
            o_rsp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            state       <= IDLE;
            o_rsp_valid <= 1'b0;
            o_req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_rsp.sv
// Bench for imem_rsp: three instances (LAT=1 with a reference model, LAT=0, LAT=3) and directed vectors.
`timescale 1ns/1ps
module tb_imem_rsp;

  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned AW    = 12;
  localparam int unsigned LAT_M = 1;
`ifdef IMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [3];
  logic          req_valid [3];
  logic          req_ready [3];
  logic [31:0]   req_addr  [3];
  logic          rsp_valid [3];
  logic          rsp_ready [3];
  logic [31:0]   rsp_ins   [3];
  logic          rsp_err   [3];
  logic          ld_wen    [3];
  logic [AW-1:0] ld_addr   [3];
  logic [31:0]   ld_data   [3];

  int checks = 0;
  int errors = 0;

  imem_rsp #(.DEPTH(DEPTH), .BASE(BASE), .LAT(LAT_M)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_addr(req_addr[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_ins(rsp_ins[0]), .o_rsp_err(rsp_err[0]),
    .i_ld_wen(ld_wen[0]), .i_ld_addr(ld_addr[0]), .i_ld_data(ld_data[0]));

  imem_rsp #(.DEPTH(DEPTH), .BASE(BASE), .LAT(0)) u_lat0 (
    .i_clk(clk), .i_rst_n(rst_n[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_addr(req_addr[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_ins(rsp_ins[1]), .o_rsp_err(rsp_err[1]),
    .i_ld_wen(ld_wen[1]), .i_ld_addr(ld_addr[1]), .i_ld_data(ld_data[1]));

  imem_rsp #(.DEPTH(DEPTH), .BASE(BASE), .LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n[2]),
    .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]), .i_req_addr(req_addr[2]),
    .o_rsp_valid(rsp_valid[2]), .i_rsp_ready(rsp_ready[2]), .o_rsp_ins(rsp_ins[2]), .o_rsp_err(rsp_err[2]),
    .i_ld_wen(ld_wen[2]), .i_ld_addr(ld_addr[2]), .i_ld_data(ld_data[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of instance 0: shadow array plus an edge-counting view of the handshake.
  logic [31:0] shadow [DEPTH];
  logic        m_ready = 1'b0, m_valid = 1'b0, m_err = 1'b0, m_pend = 1'b0, c_err = 1'b0;
  logic [31:0] m_ins = '0, c_ins = '0;
  int          m_left = 0;
  bit          model_on = 1'b0;

  function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] w, output logic e);
    logic [31:0] off;
    longint unsigned top;
    off = a - BASE;
    top = longint'(BASE) + 4 * longint'(DEPTH);
    e = ERR_EN && ((a % 4 != 0) || (a < BASE) || (longint'(a) >= top));
    w = e ? 32'h0 : shadow[(off / 4) % DEPTH];
  endfunction

  always @(posedge clk) begin
    if (ld_wen[0]) shadow[ld_addr[0]] <= ld_data[0];
  end

  always @(posedge clk or negedge rst_n[0]) begin
    if (!rst_n[0]) begin
      m_ready = 1'b0; m_valid = 1'b0; m_ins = '0; m_err = 1'b0; m_pend = 1'b0; m_left = 0;
    end else begin
      bit acc;
      acc = m_ready && req_valid[0];
      if (m_valid && rsp_ready[0]) m_valid = 1'b0;
      if (acc) begin
        ref_fetch(req_addr[0], c_ins, c_err);
        m_pend = 1'b1;
        m_left = LAT_M;
      end else if (m_pend) begin
        m_left--;
      end
      if (m_pend && m_left == 0) begin
        m_pend = 1'b0; m_valid = 1'b1; m_ins = c_ins; m_err = c_err;
      end
      m_ready = !(m_pend || m_valid);
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk1("m_req_ready", req_ready[0], m_ready);
      chk1("m_rsp_valid", rsp_valid[0], m_valid);
      if (m_valid || !rst_n[0]) begin
        chk("m_rsp_ins", rsp_ins[0], m_ins);
        chk1("m_rsp_err", rsp_err[0], m_err);
      end
    end
  end

  int unsigned cyc = 0;
  int unsigned acc_q [$];
  always @(posedge clk) begin
    if (req_valid[1] && req_ready[1]) acc_q.push_back(cyc);
    cyc++;
  end

  task automatic load_all(input logic [AW-1:0] a, input logic [31:0] v);
    for (int d = 0; d < 3; d++) begin
      ld_wen[d] = 1'b1; ld_addr[d] = a; ld_data[d] = v;
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) ld_wen[d] = 1'b0;
  endtask

  // Starts and ends on a falling edge; lat counts falling edges from acceptance to valid.
  task automatic fetch(input int d, input logic [31:0] addr, input int hold, input bit early,
                       input bit ld, input logic [AW-1:0] la, input logic [31:0] lv,
                       output logic [31:0] ins, output logic err, output int lat);
    int n;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("ready_wait", req_ready[d], 1'b1);
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    if (ld) begin
      ld_wen[d] = 1'b1; ld_addr[d] = la; ld_data[d] = lv;
    end
    if (early) rsp_ready[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    ld_wen[d]    = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk1("rsp_wait", rsp_valid[d], 1'b1);
    chk1("ready_low_in_resp", req_ready[d], 1'b0);
    ins = rsp_ins[d];
    err = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1("hold_valid", rsp_valid[d], 1'b1);
      chk("hold_ins", rsp_ins[d], ins);
      chk1("hold_ready", req_ready[d], 1'b0);
    end
    rsp_ready[d] = 1'b1;
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk1("valid_drop", rsp_valid[d], 1'b0);
    chk1("ready_back", req_ready[d], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic        err;
    int          lat;
    int          stale;

    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b0;
      ld_wen[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
    end
    model_on = 1'b1;
    @(negedge clk);
    load_all(12'd0,    32'h0010_0093);
    load_all(12'd1,    32'h0010_0073);
    load_all(12'd2,    32'h1111_1111);
    load_all(12'd3,    32'h2222_2222);
    load_all(12'd4095, 32'hCAFE_0001);

    chk1("rst_req_ready", req_ready[0], 1'b0);
    chk1("rst_rsp_valid", rsp_valid[0], 1'b0);
    chk("rst_rsp_ins", rsp_ins[0], 32'h0);
    chk1("rst_rsp_err", rsp_err[0], 1'b0);

    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
    @(negedge clk);
    chk1("post_rst_ready", req_ready[0], 1'b1);

    fetch(0, 32'h8000_0000, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("f0_ins", ins, 32'h0010_0093); chk1("f0_err", err, 1'b0); chk("f0_lat", 32'(lat), 32'd2);
    chk("pin_model_f0", c_ins, 32'h0010_0093);
    fetch(0, 32'h8000_0004, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("f1_ins", ins, 32'h0010_0073); chk1("f1_err", err, 1'b0); chk("f1_lat", 32'(lat), 32'd2);

    fetch(0, 32'h8000_0004, 5, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("bp_ins", ins, 32'h0010_0073);

    fetch(0, 32'h8000_000C, 0, 1'b1, 1'b0, '0, '0, ins, err, lat);
    chk("early_ins", ins, 32'h2222_2222); chk("early_lat", 32'(lat), 32'd2);

    fetch(0, 32'h8000_0002, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("mis_ins", ins, ERR_EN ? 32'h0 : 32'h0010_0093); chk1("mis_err", err, ERR_EN);
    fetch(0, 32'h7FFF_FFFC, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("below_ins", ins, ERR_EN ? 32'h0 : 32'hCAFE_0001); chk1("below_err", err, ERR_EN);
    chk("pin_model_below", c_ins, ERR_EN ? 32'h0 : 32'hCAFE_0001);
    fetch(0, 32'h8000_4000, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("above_ins", ins, ERR_EN ? 32'h0 : 32'h0010_0093); chk1("above_err", err, ERR_EN);
    fetch(0, 32'h8000_3FFC, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("last_ins", ins, 32'hCAFE_0001); chk1("last_err", err, 1'b0);

    fetch(0, 32'h8000_0008, 0, 1'b0, 1'b1, 12'd2, 32'hDEAD_BEEF, ins, err, lat);
    chk("rbw_old", ins, 32'h1111_1111);
    fetch(0, 32'h8000_0008, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("rbw_new", ins, 32'hDEAD_BEEF);

    fetch(1, 32'h8000_0000, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("l0_ins", ins, 32'h0010_0093); chk("l0_lat", 32'(lat), 32'd1);
    acc_q.delete();
    req_addr[1] = 32'h8000_0004; rsp_ready[1] = 1'b1; req_valid[1] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("b2b_valid", rsp_valid[1], (i % 2 == 0));
      if (i % 2 == 0) chk("b2b_ins", rsp_ins[1], 32'h0010_0073);
    end
    req_valid[1] = 1'b0; rsp_ready[1] = 1'b0;
    chk("b2b_count", acc_q.size(), 32'd4);
    for (int i = 1; i < acc_q.size(); i++) chk("b2b_spacing", acc_q[i] - acc_q[i-1], 32'd2);

    fetch(2, 32'h8000_0004, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("l3_ins", ins, 32'h0010_0073); chk("l3_lat", 32'(lat), 32'd4);
    chk("l3_held_before_rst", rsp_ins[2], 32'h0010_0073);
    req_valid[2] = 1'b1; req_addr[2] = 32'h8000_0000;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(negedge clk);
    #2 rst_n[2] = 1'b0;
    #1;
    chk1("rst_busy_valid", rsp_valid[2], 1'b0);
    chk("rst_busy_ins", rsp_ins[2], 32'h0);
    chk1("rst_busy_err", rsp_err[2], 1'b0);
    chk1("rst_busy_ready", req_ready[2], 1'b0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid[2] !== 1'b0) stale++;
    end
    chk("no_stale_rsp", 32'(stale), 32'd0);
    chk1("rst_release_ready", req_ready[2], 1'b1);
    fetch(2, 32'h8000_000C, 0, 1'b0, 1'b0, '0, '0, ins, err, lat);
    chk("l3_after_rst_ins", ins, 32'h2222_2222); chk("l3_after_rst_lat", 32'(lat), 32'd4);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
